// File: rtl/counter_sequencer_if.sv
// Host/counter bundle for counter_sequencer: host request/status plus the
// load/enable/data/count lines of one loadable up-counter.
interface counter_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             STOP;
  logic             AUTO;
  logic [WIDTH-1:0] START_VAL;
  logic [WIDTH-1:0] END_VAL;
  logic [WIDTH-1:0] COUNT;
  logic             CNT_LOAD;
  logic             CNT_ENABLE;
  logic [WIDTH-1:0] CNT_DATA;
  logic             BUSY;
  logic             DONE;

  // master: host + counter environment; slave: the sequencer
  modport master (
    output START, STOP, AUTO, START_VAL, END_VAL, COUNT,
    input  CNT_LOAD, CNT_ENABLE, CNT_DATA, BUSY, DONE
  );

  modport slave (
    input  START, STOP, AUTO, START_VAL, END_VAL, COUNT,
    output CNT_LOAD, CNT_ENABLE, CNT_DATA, BUSY, DONE
  );
endinterface

// File: rtl/counter_sequencer.sv
// Sequences an external loadable up-counter from a start value to an end value,
// with optional prescaled stepping, auto-reload and abort.
module counter_sequencer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int PW       = 8
) (
  input logic                CLK,
  input logic                RST,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, end_q;
  logic             auto_q;
  logic [PW-1:0]    presc_q;

  logic tick, at_end, latch;
  logic load_c, en_c, busy_c, done_c;

  assign tick   = (presc_q == PW'(PRESCALE - 1));
  assign at_end = (bus.COUNT == end_q);

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    load_c  = 1'b0;
    en_c    = 1'b0;
    busy_c  = 1'b1;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.START && !bus.STOP) begin
          latch   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.STOP) begin
          state_d = S_IDLE;
        end else begin
          // the counter only honours LOAD while ENABLE is high
          load_c  = 1'b1;
          en_c    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.STOP) begin
          state_d = S_IDLE;
        end else begin
          en_c = tick && !at_end;
          if (at_end) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.STOP) begin
          state_d = S_IDLE;
        end else begin
          done_c  = 1'b1;
          state_d = auto_q ? S_LOAD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      start_q <= '0;
      end_q   <= '0;
      auto_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        start_q <= bus.START_VAL;
        end_q   <= bus.END_VAL;
        auto_q  <= bus.AUTO;
      end
      // prescale phase restarts on every load so each run begins aligned
      if (state_q == S_LOAD)
        presc_q <= '0;
      else if (state_q == S_RUN)
        presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  assign bus.CNT_LOAD   = load_c;
  assign bus.CNT_ENABLE = en_c;
  assign bus.CNT_DATA   = start_q;
  assign bus.BUSY       = busy_c;
  assign bus.DONE       = done_c;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: two instances (PRESCALE 1 and 4) share
// host inputs; each drives its own behavioural 8-bit loadable counter.
module tb_counter_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, stop = 1'b0, auto = 1'b0;
  logic [7:0] sval = '0, eval = '0;
  logic [7:0] cnt_a, cnt_b;
  int tests = 0, fails = 0;

  counter_sequencer_if #(.WIDTH(8)) ifa ();
  counter_sequencer_if #(.WIDTH(8)) ifb ();

  assign ifa.START = start;  assign ifb.START = start;
  assign ifa.STOP  = stop;   assign ifb.STOP  = stop;
  assign ifa.AUTO  = auto;   assign ifb.AUTO  = auto;
  assign ifa.START_VAL = sval; assign ifb.START_VAL = sval;
  assign ifa.END_VAL   = eval; assign ifb.END_VAL   = eval;
  assign ifa.COUNT = cnt_a;  assign ifb.COUNT = cnt_b;

  counter_sequencer #(.WIDTH(8), .PRESCALE(1), .PW(8)) dut_a (.CLK(clk), .RST(rst), .bus(ifa));
  counter_sequencer #(.WIDTH(8), .PRESCALE(4), .PW(8)) dut_b (.CLK(clk), .RST(rst), .bus(ifb));

  // behavioural loadable up-counter (load/increment only while ENABLE is high)
  always_ff @(posedge clk) begin
    if (rst) cnt_a <= '0;
    else if (ifa.CNT_ENABLE) cnt_a <= ifa.CNT_LOAD ? ifa.CNT_DATA : cnt_a + 8'd1;
    if (rst) cnt_b <= '0;
    else if (ifb.CNT_ENABLE) cnt_b <= ifb.CNT_LOAD ? ifb.CNT_DATA : cnt_b + 8'd1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stop = 1'b0; auto = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // START sampled at the next rising edge (edge 0); returns just after it
  task automatic kick(input logic [7:0] sv, input logic [7:0] ev, input logic au);
    @(negedge clk);
    sval = sv; eval = ev; auto = au; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({ifa.CNT_LOAD, ifa.CNT_ENABLE, ifa.BUSY, ifa.DONE} !== 4'b0 || ifa.CNT_DATA !== 8'd0) begin
      fails++;
      $display("FAIL reset_a: load=%b en=%b busy=%b done=%b data=%0d, required all 0",
               ifa.CNT_LOAD, ifa.CNT_ENABLE, ifa.BUSY, ifa.DONE, ifa.CNT_DATA);
    end
    tests++;
    if ({ifb.CNT_LOAD, ifb.CNT_ENABLE, ifb.BUSY, ifb.DONE} !== 4'b0 || ifb.CNT_DATA !== 8'd0) begin
      fails++;
      $display("FAIL reset_b: load=%b en=%b busy=%b done=%b data=%0d, required all 0",
               ifb.CNT_LOAD, ifb.CNT_ENABLE, ifb.BUSY, ifb.DONE, ifb.CNT_DATA);
    end
  endtask

  task automatic test_basic();
    int n_load = 0, load_cyc = -1, n_en = 0, n_done = 0, done_cyc = -1, busy_bad = 0;
    logic [7:0] load_data = '0, cnt_done = '0;
    do_reset();
    kick(8'd10, 8'd15, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ifa.CNT_LOAD) begin n_load++; load_cyc = c; load_data = ifa.CNT_DATA; end
      if (ifa.CNT_ENABLE && !ifa.CNT_LOAD) n_en++;
      if (ifa.DONE) begin n_done++; done_cyc = c; cnt_done = cnt_a; end
      if (c <= 8 && ifa.BUSY !== 1'b1) busy_bad++;
      if (c >= 2 && c <= 7) begin
        tests++;
        if (cnt_a !== 8'(8 + c)) begin
          fails++; $display("FAIL basic_count c%0d: got %0d, required %0d", c, cnt_a, 8 + c);
        end
      end
      if (c == 9) begin
        tests++;
        if (ifa.BUSY !== 1'b0) begin fails++; $display("FAIL basic_busy_low: got %b, required 0", ifa.BUSY); end
      end
    end
    tests++; if (n_load !== 1 || load_cyc !== 1) begin fails++; $display("FAIL basic_load: %0d pulses at cycle %0d, required 1 at 1", n_load, load_cyc); end
    tests++; if (load_data !== 8'd10) begin fails++; $display("FAIL basic_data: got %0d, required 10", load_data); end
    tests++; if (n_en !== 5) begin fails++; $display("FAIL basic_enables: got %0d, required 5", n_en); end
    tests++; if (n_done !== 1 || done_cyc !== 8) begin fails++; $display("FAIL basic_done: %0d pulses at cycle %0d, required 1 at 8", n_done, done_cyc); end
    tests++; if (cnt_done !== 8'd15) begin fails++; $display("FAIL basic_final: got %0d, required 15", cnt_done); end
    tests++; if (busy_bad !== 0) begin fails++; $display("FAIL basic_busy_high: %0d low cycles, required 0", busy_bad); end
  endtask

  task automatic test_wrap();
    int n_en = 0, done_cyc = -1;
    logic [7:0] cnt_done = '0;
    do_reset();
    kick(8'd250, 8'd4, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ifa.CNT_ENABLE && !ifa.CNT_LOAD) n_en++;
      if (ifa.DONE) begin done_cyc = c; cnt_done = cnt_a; end
    end
    tests++; if (n_en !== 10) begin fails++; $display("FAIL wrap_enables: got %0d, required 10", n_en); end
    tests++; if (done_cyc !== 13) begin fails++; $display("FAIL wrap_done: cycle %0d, required 13", done_cyc); end
    tests++; if (cnt_done !== 8'd4) begin fails++; $display("FAIL wrap_final: got %0d, required 4", cnt_done); end
  endtask

  task automatic test_equal();
    int n_en = 0, n_done = 0, done_cyc = -1;
    do_reset();
    kick(8'h7F, 8'h7F, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (ifa.CNT_ENABLE && !ifa.CNT_LOAD) n_en++;
      if (ifa.DONE) begin n_done++; done_cyc = c; end
    end
    tests++; if (n_en !== 0) begin fails++; $display("FAIL equal_enables: got %0d, required 0", n_en); end
    tests++; if (n_done !== 1 || done_cyc !== 3) begin fails++; $display("FAIL equal_done: %0d pulses at cycle %0d, required 1 at 3", n_done, done_cyc); end
  endtask

  task automatic test_prescale();
    logic [31:0] en_mask = '0;
    int done_cyc = -1;
    logic [7:0] cnt_done = '0;
    do_reset();
    kick(8'd0, 8'd3, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (ifb.CNT_ENABLE && !ifb.CNT_LOAD) en_mask[c] = 1'b1;
      if (ifb.DONE) begin done_cyc = c; cnt_done = cnt_b; end
    end
    tests++; if (en_mask !== 32'h0000_2220) begin fails++; $display("FAIL presc_enables: mask %h, required 00002220", en_mask); end
    tests++; if (done_cyc !== 15) begin fails++; $display("FAIL presc_done: cycle %0d, required 15", done_cyc); end
    tests++; if (cnt_done !== 8'd3) begin fails++; $display("FAIL presc_final: got %0d, required 3", cnt_done); end
  endtask

  task automatic test_auto();
    logic [31:0] load_mask = '0, done_mask = '0;
    do_reset();
    kick(8'd0, 8'd3, 1'b1);
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      if (ifb.CNT_LOAD) load_mask[c] = 1'b1;
      if (ifb.DONE) done_mask[c] = 1'b1;
    end
    tests++; if (load_mask !== 32'h8001_0002) begin fails++; $display("FAIL auto_loads: mask %h, required 80010002", load_mask); end
    tests++; if (done_mask !== 32'h4000_8000) begin fails++; $display("FAIL auto_dones: mask %h, required 40008000", done_mask); end
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    tests++; if (ifb.BUSY !== 1'b0) begin fails++; $display("FAIL auto_stop: busy %b, required 0", ifb.BUSY); end
  endtask

  task automatic test_stop();
    int n_done = 0, frozen_bad = 0;
    do_reset();
    kick(8'd10, 8'd15, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ifa.DONE) n_done++;
      if (c == 4) begin
        tests++; if (cnt_a !== 8'd12) begin fails++; $display("FAIL stop_at12: count %0d, required 12", cnt_a); end
        stop = 1'b1;
        #1;
        tests++;
        if (ifa.CNT_ENABLE !== 1'b0 || ifa.CNT_LOAD !== 1'b0) begin
          fails++; $display("FAIL stop_enable: en=%b load=%b, required 0 0", ifa.CNT_ENABLE, ifa.CNT_LOAD);
        end
      end
      if (c == 5) begin
        stop = 1'b0;
        tests++; if (ifa.BUSY !== 1'b0) begin fails++; $display("FAIL stop_idle: busy %b, required 0", ifa.BUSY); end
      end
      if (c >= 5 && cnt_a !== 8'd12) frozen_bad++;
    end
    tests++; if (frozen_bad !== 0) begin fails++; $display("FAIL stop_frozen: %0d cycles off 12", frozen_bad); end
    tests++; if (n_done !== 0) begin fails++; $display("FAIL stop_nodone: %0d pulses, required 0", n_done); end
  endtask

  task automatic test_start_stop();
    int busy_bad = 0;
    do_reset();
    @(negedge clk);
    sval = 8'd55; eval = 8'd60; start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; stop = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (ifa.BUSY !== 1'b0 || ifb.BUSY !== 1'b0) busy_bad++;
    end
    tests++; if (busy_bad !== 0) begin fails++; $display("FAIL startstop_busy: %0d busy cycles, required 0", busy_bad); end
    tests++; if (ifa.CNT_DATA !== 8'd0) begin fails++; $display("FAIL startstop_nolatch: data %0d, required 0", ifa.CNT_DATA); end
  endtask

  task automatic test_start_busy();
    int done_cyc = -1;
    logic [7:0] cnt_done = '0, data6 = '0;
    do_reset();
    kick(8'd10, 8'd15, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ifa.DONE) begin done_cyc = c; cnt_done = cnt_a; end
      if (c == 6) data6 = ifa.CNT_DATA;
      if (c == 4) begin sval = 8'd99; start = 1'b1; end
      if (c == 5) start = 1'b0;
    end
    tests++; if (done_cyc !== 8) begin fails++; $display("FAIL busystart_done: cycle %0d, required 8", done_cyc); end
    tests++; if (cnt_done !== 8'd15) begin fails++; $display("FAIL busystart_final: got %0d, required 15", cnt_done); end
    tests++; if (data6 !== 8'd10) begin fails++; $display("FAIL busystart_data: got %0d, required 10", data6); end
  endtask

  task automatic test_rst_mid();
    int n_done = 0, busy_bad = 0;
    do_reset();
    kick(8'd10, 8'd15, 1'b0);
    for (int c = 1; c <= 4; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({ifa.CNT_LOAD, ifa.CNT_ENABLE, ifa.BUSY, ifa.DONE} !== 4'b0 || ifa.CNT_DATA !== 8'd0) begin
      fails++;
      $display("FAIL rstmid_outputs: load=%b en=%b busy=%b done=%b data=%0d, required all 0",
               ifa.CNT_LOAD, ifa.CNT_ENABLE, ifa.BUSY, ifa.DONE, ifa.CNT_DATA);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ifa.DONE) n_done++;
      if (ifa.BUSY) busy_bad++;
    end
    tests++; if (n_done !== 0 || busy_bad !== 0) begin fails++; $display("FAIL rstmid_idle: done %0d busy %0d, required 0 0", n_done, busy_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_equal();
    test_prescale();
    test_auto();
    test_stop();
    test_start_stop();
    test_start_busy();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
